stuff_or_data_lanes: RTL and testbench

Parametrised multi-lane successor to the single-lane stuff/data decision block in the packet mapper. Per frame it captures a payload slot count `pm` and data slot count `cm`. Across the `pm` slots it spreads exactly `cm` data decisions (`ds=1`) as evenly as possible, with `pm-cm` stuff decisions (`ds=0`). It resolves `LANES` slots per input beat and adds frame-error reporting.

---
 rtl/stuff_or_data_pkg.sv | 10 +
 rtl/sod_lane_step.sv | 20 ++
 rtl/stuff_or_data_lanes.sv | 107 ++++++++++
 tb/tb_stuff_or_data_lanes.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stuff_or_data_pkg.sv
// stuff_or_data_pkg: shared state enum, legal lane counts and LANES elaboration check.
package stuff_or_data_pkg;
   typedef enum logic {IDLE, RUN} sod_state_e;
   localparam int LANES_MIN = 1;
   localparam int LANES_MID = 2;
   localparam int LANES_MAX = 4;
   function automatic bit lanes_ok(input int l);
      return l == LANES_MIN || l == LANES_MID || l == LANES_MAX;
   endfunction
endpackage

// File: rtl/sod_lane_step.sv
// sod_lane_step: one slot of the stuff/data accumulator; chained once per lane.
module sod_lane_step #(
   parameter int MPT_W = 8
) (
   input  logic [MPT_W:0]   acc,
   input  logic [MPT_W-1:0] cm,
   input  logic [MPT_W-1:0] pm,
   input  logic             slot_ok,
   output logic             ds,
   output logic             lane_vld,
   output logic [MPT_W:0]   acc_next
);
   logic [MPT_W:0] t;
   logic           ge;
   assign t        = acc + {1'b0, cm};
   assign ge       = t >= {1'b0, pm};
   assign ds       = slot_ok & ge;
   assign lane_vld = slot_ok;
   assign acc_next = !slot_ok ? acc : ge ? t - {1'b0, pm} : t;
endmodule

// File: rtl/stuff_or_data_lanes.sv
// stuff_or_data_lanes: spreads cm data slots evenly over pm payload slots, LANES slots per beat.
// Define SOD_ERR_FLAGS_EN to add err_sof_early/err_sof_late and frame restart on sof_in in RUN.
module stuff_or_data_lanes
   import stuff_or_data_pkg::*;
#(
   parameter int MPT_W = 8,
   parameter int LANES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [MPT_W-1:0] pm,
   input  logic [MPT_W-1:0] cm,
   input  logic             sof_in,
   input  logic             valid_in,
   output logic             sof_out,
   output logic             valid_out,
   output logic [LANES-1:0] ds,
   output logic [LANES-1:0] lane_vld,
   output logic             eof_out,
   output logic             cfg_err
`ifdef SOD_ERR_FLAGS_EN
   ,
   output logic             err_sof_early,
   output logic             err_sof_late
`endif
);
   generate
      if (!lanes_ok(LANES)) begin : g_bad_lanes
         $error("stuff_or_data_lanes: LANES must be 1, 2 or 4");
      end
   endgenerate

`ifdef SOD_ERR_FLAGS_EN
   localparam bit RESTART = 1'b1;
`else
   localparam bit RESTART = 1'b0;
`endif

   sod_state_e       state;
   logic [MPT_W-1:0] pm_r, cm_r;
   logic [MPT_W:0]   acc, cnt;
   logic [MPT_W:0]   acc_c [0:LANES];
   logic [LANES-1:0] ds_c, vld_c;
   logic             cfg_ok, sof_take, beat, last;

   assign cfg_ok   = pm != '0 && cm <= pm;
   assign sof_take = sof_in && (state == IDLE || RESTART);
   assign beat     = valid_in && state == RUN && !sof_take;
   assign last     = cnt + (MPT_W+1)'(LANES) >= {1'b0, pm_r};
   assign acc_c[0] = acc;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      sod_lane_step #(.MPT_W(MPT_W)) u_step (
         .acc      (acc_c[k]),
         .cm       (cm_r),
         .pm       (pm_r),
         .slot_ok  (cnt + (MPT_W+1)'(k + 1) <= {1'b0, pm_r}),
         .ds       (ds_c[k]),
         .lane_vld (vld_c[k]),
         .acc_next (acc_c[k+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pm_r      <= '0;
         cm_r      <= '0;
         acc       <= '0;
         cnt       <= '0;
         sof_out   <= 1'b0;
         cfg_err   <= 1'b0;
         valid_out <= 1'b0;
         ds        <= '0;
         lane_vld  <= '0;
         eof_out   <= 1'b0;
`ifdef SOD_ERR_FLAGS_EN
         err_sof_early <= 1'b0;
         err_sof_late  <= 1'b0;
`endif
      end else begin
         sof_out   <= sof_take && cfg_ok;
         cfg_err   <= sof_take && !cfg_ok;
         valid_out <= beat;
         ds        <= beat ? ds_c : '0;
         lane_vld  <= beat ? vld_c : '0;
         eof_out   <= beat && last;
`ifdef SOD_ERR_FLAGS_EN
         err_sof_early <= sof_in && state == RUN;
         err_sof_late  <= valid_in && !sof_in && state == IDLE;
`endif
         if (sof_take) begin
            state <= cfg_ok ? RUN : IDLE;
            if (cfg_ok) begin
               pm_r <= pm;
               cm_r <= cm;
               acc  <= '0;
               cnt  <= '0;
            end
         end else if (beat) begin
            acc <= acc_c[LANES];
            cnt <= cnt + (MPT_W+1)'(LANES);
            if (last) state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_stuff_or_data_lanes.sv
// tb_stuff_or_data_lanes: LANES=1 and LANES=4 instances against a floor-formula frame model.
module tb_stuff_or_data_lanes;
`ifdef SOD_ERR_FLAGS_EN
   localparam bit RESTART = 1'b1;
`else
   localparam bit RESTART = 1'b0;
`endif

   typedef struct {
      bit run;
      int pm, cm, n;
      bit sof, vld, eof, cfg, early, late;
      int ds, lv;
   } model_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pm = '0, cm = '0;
   logic       sof_in = 1'b0, valid_in = 1'b0;
   logic       sof1, vo1, eof1, cfg1, sof4, vo4, eof4, cfg4;
   logic [0:0] ds1, lv1;
   logic [3:0] ds4, lv4;
   logic       early1, late1, early4, late4;
   int         tests = 0, fails = 0;
   model_t     m1, m4;

   always #5 clk = ~clk;

   stuff_or_data_lanes #(.MPT_W(8), .LANES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .pm(pm), .cm(cm), .sof_in(sof_in), .valid_in(valid_in),
      .sof_out(sof1), .valid_out(vo1), .ds(ds1), .lane_vld(lv1), .eof_out(eof1), .cfg_err(cfg1)
`ifdef SOD_ERR_FLAGS_EN
      , .err_sof_early(early1), .err_sof_late(late1)
`endif
   );
   stuff_or_data_lanes #(.MPT_W(8), .LANES(4)) u4 (
      .clk(clk), .rst_n(rst_n), .pm(pm), .cm(cm), .sof_in(sof_in), .valid_in(valid_in),
      .sof_out(sof4), .valid_out(vo4), .ds(ds4), .lane_vld(lv4), .eof_out(eof4), .cfg_err(cfg4)
`ifdef SOD_ERR_FLAGS_EN
      , .err_sof_early(early4), .err_sof_late(late4)
`endif
   );
`ifndef SOD_ERR_FLAGS_EN
   assign {early1, late1, early4, late4} = '0;
`endif

   function automatic model_t step(input model_t s, input int l, input bit sof, input bit vld,
                                   input int p, input int c);
      model_t r = s;
      bit take = sof && (!s.run || RESTART);
      r.sof = 0; r.vld = 0; r.eof = 0; r.cfg = 0; r.early = 0; r.late = 0; r.ds = 0; r.lv = 0;
      if (RESTART) begin
         r.early = sof && s.run;
         r.late  = vld && !sof && !s.run;
      end
      if (take) begin
         if (p != 0 && c <= p) begin
            r.run = 1; r.pm = p; r.cm = c; r.n = 0; r.sof = 1;
         end else begin
            r.run = 0; r.cfg = 1;
         end
      end else if (vld && s.run) begin
         r.vld = 1;
         for (int k = 0; k < l; k++) begin
            int i = s.n + k + 1;
            if (i <= s.pm) begin
               r.lv |= 1 << k;
               if ((i * s.cm) / s.pm > ((i - 1) * s.cm) / s.pm) r.ds |= 1 << k;
            end
         end
         r.n = s.n + l;
         if (r.n >= s.pm) begin
            r.eof = 1; r.run = 0;
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= '{default: 0};
         m4 <= '{default: 0};
      end else begin
         m1 <= step(m1, 1, sof_in, valid_in, int'(pm), int'(cm));
         m4 <= step(m4, 4, sof_in, valid_in, int'(pm), int'(cm));
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("u1.sof_out", int'(sof1), int'(m1.sof));
      chk("u1.valid_out", int'(vo1), int'(m1.vld));
      chk("u1.ds", int'(ds1), m1.ds);
      chk("u1.lane_vld", int'(lv1), m1.lv);
      chk("u1.eof_out", int'(eof1), int'(m1.eof));
      chk("u1.cfg_err", int'(cfg1), int'(m1.cfg));
      chk("u1.err_sof_early", int'(early1), int'(m1.early));
      chk("u1.err_sof_late", int'(late1), int'(m1.late));
      chk("u4.sof_out", int'(sof4), int'(m4.sof));
      chk("u4.valid_out", int'(vo4), int'(m4.vld));
      chk("u4.ds", int'(ds4), m4.ds);
      chk("u4.lane_vld", int'(lv4), m4.lv);
      chk("u4.eof_out", int'(eof4), int'(m4.eof));
      chk("u4.cfg_err", int'(cfg4), int'(m4.cfg));
      chk("u4.err_sof_early", int'(early4), int'(m4.early));
      chk("u4.err_sof_late", int'(late4), int'(m4.late));
   end

   task automatic drive(input bit s, input bit v, input int p, input int c);
      sof_in = s; valid_in = v; pm = 8'(p); cm = 8'(c);
      @(posedge clk); #1;
      sof_in = 0; valid_in = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " u1 outs"}, int'({sof1, vo1, ds1, lv1, eof1, cfg1, early1, late1}), 0);
      chk({tag, " u4 outs"}, int'({sof4, vo4, ds4, lv4, eof4, cfg4, early4, late4}), 0);
   endtask

   task automatic frame_1010(input string tag);
      logic [3:0] seq;
      drive(1, 0, 4, 2);
      chk({tag, " sof_out"}, int'(sof1), 1);
      for (int b = 0; b < 4; b++) begin
         drive(0, 1, 0, 0);
         seq[b] = ds1[0];
         chk({tag, " eof timing"}, int'(eof1), b == 3 ? 1 : 0);
      end
      chk({tag, " ds seq"}, int'(seq), 4'b1010);
   endtask

   initial begin
      int ones;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1;
      drive(0, 0, 0, 0);

      frame_1010("p4c2");

      drive(1, 0, 7, 7);
      ones = 0;
      for (int b = 0; b < 7; b++) begin
         drive(0, 1, 0, 0);
         ones += int'(ds1[0]);
      end
      chk("p7c7 ones", ones, 7);
      chk("p7c7 eof", int'(eof1), 1);
      drive(1, 0, 5, 0);
      ones = 0;
      for (int b = 0; b < 5; b++) begin
         drive(0, 1, 0, 0);
         ones += int'(ds1[0]);
      end
      chk("p5c0 ones", ones, 0);

      drive(1, 0, 6, 3);
      drive(0, 1, 0, 0);
      chk("l4 beat1 ds", int'(ds4), 4'b1010);
      chk("l4 beat1 vld", int'(lv4), 4'b1111);
      chk("l4 beat1 eof", int'(eof4), 0);
      drive(0, 1, 0, 0);
      chk("l4 beat2 ds", int'(ds4), 4'b0010);
      chk("l4 beat2 vld", int'(lv4), 4'b0011);
      chk("l4 beat2 eof", int'(eof4), 1);
      repeat (4) drive(0, 1, 0, 0);
      chk("l1 p6 eof", int'(eof1), 1);

      drive(1, 0, 3, 5);
      chk("p3c5 cfg_err", int'(cfg1), 1);
      chk("p3c5 sof_out", int'(sof1), 0);
      drive(0, 1, 0, 0);
      chk("p3c5 no valid", int'(vo1), 0);
      drive(1, 0, 0, 0);
      chk("p0c0 cfg_err", int'(cfg4), 1);
      drive(0, 1, 0, 0);
      chk("p0c0 no valid", int'(vo4), 0);

`ifdef SOD_ERR_FLAGS_EN
      drive(1, 0, 8, 3);
      repeat (2) drive(0, 1, 0, 0);
      drive(1, 0, 4, 4);
      chk("early flag", int'(early1), 1);
      ones = 0;
      for (int b = 0; b < 4; b++) begin
         drive(0, 1, 0, 0);
         ones += int'(ds1[0]);
      end
      chk("restart ones", ones, 4);
      chk("restart eof", int'(eof1), 1);
      drive(0, 1, 0, 0);
      chk("late flag", int'(late1), 1);
`endif

      drive(1, 0, 10, 5);
      repeat (3) drive(0, 1, 0, 0);
      chk("pre-reset valid", int'(vo1), 1);
      rst_n = 0;
      #1;
      chk_all_zero("async reset");
      @(posedge clk); #1;
      rst_n = 1;
      drive(0, 0, 0, 0);
      frame_1010("post reset");
      repeat (3) drive(0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
